apb_reg_slave: RTL and testbench

// - APB completer directly downstream of the AXI-to-APB bridge.
// - Consumes axi2apb::apb_req_t plus a per-slave psel and returns axi2apb::apb_resp_t.
// - Implements NumRegs 32-bit word registers with byte strobes and per-register read-only masking.
// - Optionally inserts programmable wait states.
//

---
 rtl/apb_reg_slave.sv | 176 +++++++++++++++++
 tb/tb_apb_reg_slave.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_reg_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_reg_slave : APB completer with NumRegs 32-bit byte-strobed registers,  |
// | per-register read-only masking and optional APB_REG_SLAVE_WAIT_EN waits.   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+

package axi2apb;
  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_req_t;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_resp_t;
endpackage

module apb_reg_slave #(
  parameter int unsigned         NumRegs    = 16,
  parameter logic [31:0]         BaseAddr   = 32'h0,
  parameter logic [31:0]         RstVal     = 32'h0,
  parameter logic [NumRegs-1:0]  RoMask     = '0,
  parameter int unsigned         WaitCycles = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    psel_i,
  input  axi2apb::apb_req_t       apb_req_i,
  output axi2apb::apb_resp_t      apb_resp_o,
  input  logic [NumRegs*32-1:0]   reg_ro_i,
  output logic [NumRegs*32-1:0]   reg_q_o,
  output logic [NumRegs-1:0]      wr_pulse_o
);

  logic                      access;
  logic [31:0]               off;
  logic [NumRegs-1:0]        sel;
  logic                      err;
  logic                      pready;
  logic                      commit;
  logic [31:0]               rd_val;
  logic [NumRegs-1:0][31:0]  reg_val;
  logic [NumRegs-1:0]        wr_pulse_d;
  logic [NumRegs-1:0]        wr_pulse_q;

  assign access = psel_i & apb_req_i.penable;
  assign off    = apb_req_i.paddr - BaseAddr;

  // One-hot word select; an all-zero vector means the offset is out of range.
  always_comb begin
    sel = '0;
    for (int i = 0; i < int'(NumRegs); i++) begin
      sel[i] = (off[31:2] == 30'(i));
    end
  end

  assign err = ~(|sel) | (apb_req_i.paddr[1:0] != 2'b00)
             | (apb_req_i.pwrite & (|(sel & RoMask)));

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < int'(NumRegs); i++) begin
      if (sel[i]) rd_val = reg_val[i];
    end
  end

`ifdef APB_REG_SLAVE_WAIT_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // pready is issued on the completing penable cycle so latency is WaitCycles+1;
  // RESP then marks the single post-completion cycle before returning to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          if (WaitCycles == 0) begin
            pready  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WaitCycles - 1);
          end
        end
      end
      WAIT: begin
        if (!access) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          pready  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
`else
  assign pready = access;
`endif

  assign commit = pready & apb_req_i.pwrite & ~err;

  assign apb_resp_o.pready  = pready;
  assign apb_resp_o.pslverr = pready & err;
  assign apb_resp_o.prdata  = (pready & ~err & ~apb_req_i.pwrite) ? rd_val : 32'h0;

  for (genvar i = 0; i < int'(NumRegs); i++) begin : g_reg
    if (RoMask[i]) begin : g_ro
      assign reg_val[i]          = reg_ro_i[32*i +: 32];
      assign reg_q_o[32*i +: 32] = 32'h0;
    end else begin : g_rw
      logic [31:0] data_q, data_d;

      always_comb begin
        data_d = data_q;
        if (commit && sel[i]) begin
          for (int b = 0; b < 4; b++) begin
            if (apb_req_i.pstrb[b]) data_d[8*b +: 8] = apb_req_i.pwdata[8*b +: 8];
          end
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) data_q <= RstVal;
        else       data_q <= data_d;
      end

      assign reg_val[i]          = data_q;
      assign reg_q_o[32*i +: 32] = data_q;
    end
  end

  assign wr_pulse_d = commit ? sel : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) wr_pulse_q <= '0;
    else       wr_pulse_q <= wr_pulse_d;
  end

  assign wr_pulse_o = wr_pulse_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, apb_req_i.pprot, off[1:0], reg_ro_i, 4'(WaitCycles)};

endmodule

`default_nettype wire

// File: tb/tb_apb_reg_slave.sv
`default_nettype none
// Self-checking bench for apb_reg_slave: directed vector table, hand sequences
// and randomized transfers scored against an array-based register model.

module tb_apb_reg_slave;

  localparam int          N    = 8;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] RSTV = 32'h5A5A_0000;
  localparam logic [N-1:0] ROM = 8'b0100_1000;
  localparam int          WC   = 2;
`ifdef APB_REG_SLAVE_WAIT_EN
  localparam int EXP_LAT = WC + 1;
`else
  localparam int EXP_LAT = 1;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                psel;
  axi2apb::apb_req_t   req;
  axi2apb::apb_resp_t  resp;
  logic [N*32-1:0]     reg_ro;
  logic [N*32-1:0]     reg_q;
  logic [N-1:0]        wr_pulse;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_reg [N];
  logic [N-1:0] ro_mask = ROM;

  apb_reg_slave #(
    .NumRegs(N), .BaseAddr(BASE), .RstVal(RSTV), .RoMask(ROM), .WaitCycles(WC)
  ) dut (
    .clk_i(clk), .rst_i(rst), .psel_i(psel), .apb_req_i(req), .apb_resp_o(resp),
    .reg_ro_i(reg_ro), .reg_q_o(reg_q), .wr_pulse_o(wr_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic         wr;
    logic [31:0]  wd;
    logic [3:0]   st;
    logic         err;
    logic [31:0]  rd;
    logic [N-1:0] pulse;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [N*32-1:0] act, input logic [N*32-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [N*32-1:0] exp_regq();
    logic [N*32-1:0] v;
    for (int i = 0; i < N; i++) v[32*i +: 32] = ro_mask[i] ? 32'h0 : m_reg[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_reg[i] = RSTV;
  endtask

  // Reference behaviour computed from the address map rules directly.
  task automatic model_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                            input logic [3:0] st, output logic e, output logic [31:0] rd,
                            output logic [N-1:0] pulse);
    logic [31:0] o;
    int idx;
    o     = addr - BASE;
    e     = 1'b0;
    rd    = 32'h0;
    pulse = '0;
    if (o >= 32'(N*4) || addr[1:0] != 2'b00) e = 1'b1;
    else begin
      idx = int'(o / 4);
      if (wr && ro_mask[idx]) e = 1'b1;
      else if (!wr) rd = ro_mask[idx] ? reg_ro[32*idx +: 32] : m_reg[idx];
      else begin
        for (int b = 0; b < 4; b++) if (st[b]) m_reg[idx][8*b +: 8] = wd[8*b +: 8];
        pulse[idx] = 1'b1;
      end
    end
  endtask

  // Starts with setup at the current time; returns one cycle after completion.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic e,
                      output logic [N-1:0] pulse, output int lat);
    bit done;
    psel        = 1'b1;
    req.penable = 1'b0;
    req.paddr   = addr;
    req.pwrite  = wr;
    req.pwdata  = wd;
    req.pstrb   = st;
    req.pprot   = 3'($urandom);
    rd = 32'h0; e = 1'b0; lat = 0; done = 1'b0;
    @(posedge clk); #1;
    req.penable = 1'b1;
    while (!done && lat < 20) begin
      #1;
      lat++;
      if (resp.pready) begin
        rd   = resp.prdata;
        e    = resp.pslverr;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    pulse       = wr_pulse;
    psel        = 1'b0;
    req.penable = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout addr=%h actual=no_pready required=pready", addr);
    end
  endtask

  task automatic run_one(input string nm, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wd, input logic [3:0] st);
    logic e_m, e_d;
    logic [31:0] rd_m, rd_d;
    logic [N-1:0] p_m, p_d;
    int lat;
    model_xfer(addr, wr, wd, st, e_m, rd_m, p_m);
    xfer(addr, wr, wd, st, rd_d, e_d, p_d, lat);
    chk({nm, "_err"}, N*32'(e_d), N*32'(e_m));
    if (!wr) chk({nm, "_rdata"}, N*32'(rd_d), N*32'(rd_m));
    chk({nm, "_pulse"}, N*32'(p_d), N*32'(p_m));
    chk({nm, "_regq"}, reg_q, exp_regq());
  endtask

  initial begin
    logic e_m, e_d;
    logic [31:0] rd_m, rd_d, a;
    logic [N-1:0] p_m, p_d;
    logic [N*32-1:0] snap;
    int lat;

    tbl[0]  = '{BASE + 32'd8,  1'b1, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        8'h04};
    tbl[1]  = '{BASE + 32'd8,  1'b0, 32'h0,        4'hF, 1'b0, 32'hDEADBEEF, 8'h00};
    tbl[2]  = '{BASE + 32'd4,  1'b1, 32'h11223344, 4'hF, 1'b0, 32'h0,        8'h02};
    tbl[3]  = '{BASE + 32'd4,  1'b1, 32'hAABBCCDD, 4'h5, 1'b0, 32'h0,        8'h02};
    tbl[4]  = '{BASE + 32'd4,  1'b0, 32'h0,        4'h0, 1'b0, 32'h11BB33DD, 8'h00};
    tbl[5]  = '{BASE + 32'd12, 1'b0, 32'h0,        4'h0, 1'b0, 32'hCAFE0003, 8'h00};
    tbl[6]  = '{BASE + 32'd12, 1'b1, 32'h12345678, 4'hF, 1'b1, 32'h0,        8'h00};
    tbl[7]  = '{BASE + 32'd32, 1'b0, 32'h0,        4'h0, 1'b1, 32'h0,        8'h00};
    tbl[8]  = '{BASE + 32'd2,  1'b0, 32'h0,        4'h0, 1'b1, 32'h0,        8'h00};
    tbl[9]  = '{BASE + 32'd2,  1'b1, 32'h55555555, 4'hF, 1'b1, 32'h0,        8'h00};
    tbl[10] = '{BASE + 32'd20, 1'b1, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0,        8'h20};
    tbl[11] = '{BASE + 32'd20, 1'b0, 32'h0,        4'h0, 1'b0, RSTV,         8'h00};
    tbl[12] = '{BASE - 32'd4,  1'b0, 32'h0,        4'h0, 1'b1, 32'h0,        8'h00};

    for (int i = 0; i < N; i++) reg_ro[32*i +: 32] = 32'hCAFE0000 | 32'(i);
    rst  = 1'b1;
    psel = 1'b0;
    req  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready", N*32'(resp.pready), '0);
    chk("rst_pslverr", N*32'(resp.pslverr), '0);
    chk("rst_prdata", N*32'(resp.prdata), '0);
    chk("rst_pulse", N*32'(wr_pulse), '0);
    chk("rst_regq", reg_q, exp_regq());
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 13; k++) begin
      model_xfer(tbl[k].addr, tbl[k].wr, tbl[k].wd, tbl[k].st, e_m, rd_m, p_m);
      xfer(tbl[k].addr, tbl[k].wr, tbl[k].wd, tbl[k].st, rd_d, e_d, p_d, lat);
      chk($sformatf("tbl%0d_err", k), N*32'(e_d), N*32'(tbl[k].err));
      if (!tbl[k].wr) chk($sformatf("tbl%0d_rdata", k), N*32'(rd_d), N*32'(tbl[k].rd));
      chk($sformatf("tbl%0d_pulse", k), N*32'(p_d), N*32'(tbl[k].pulse));
      chk($sformatf("tbl%0d_lat", k), N*32'(lat), N*32'(EXP_LAT));
      chk($sformatf("tbl%0d_regq", k), reg_q, exp_regq());
      if (k == 0) begin
        @(posedge clk); #1;
        chk("pulse_one_cycle", N*32'(wr_pulse), '0);
      end
    end

`ifdef APB_REG_SLAVE_WAIT_EN
    // Abort in WAIT: master drops psel before pready.
    snap        = reg_q;
    psel        = 1'b1;
    req.paddr   = BASE;
    req.pwrite  = 1'b1;
    req.pwdata  = 32'h0BAD0BAD;
    req.pstrb   = 4'hF;
    req.penable = 1'b0;
    @(posedge clk); #1;
    req.penable = 1'b1;
    @(posedge clk); #1;
    psel        = 1'b0;
    req.penable = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_pulse", N*32'(wr_pulse), '0);
    end
    chk("abort_regq", reg_q, snap);
`endif

    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < N; i++) reg_ro[32*i +: 32] = $urandom;
      if ($urandom_range(0, 7) == 0) a = BASE - 32'(4 * $urandom_range(1, 2));
      else                           a = BASE + 32'($urandom_range(0, N*4 + 7));
      run_one($sformatf("rnd%0d", k), a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end

    // Back-to-back: second setup directly follows the first completion.
    run_one("b2b_w", BASE + 32'd28, 1'b1, 32'h76543210, 4'hF);
    run_one("b2b_r", BASE + 32'd28, 1'b0, 32'h0, 4'h0);

`ifdef APB_REG_SLAVE_WAIT_EN
    psel        = 1'b1;
    req.paddr   = BASE;
    req.pwrite  = 1'b1;
    req.pwdata  = 32'h13572468;
    req.pstrb   = 4'hF;
    req.penable = 1'b0;
    @(posedge clk); #1;
    req.penable = 1'b1;
    @(posedge clk); #1;
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    chk("rstw_pready", N*32'(resp.pready), '0);
    chk("rstw_pulse", N*32'(wr_pulse), '0);
    chk("rstw_regq", reg_q, exp_regq());
    rst         = 1'b0;
    psel        = 1'b0;
    req.penable = 1'b0;
    @(posedge clk); #1;
    run_one("post_rst", BASE + 32'd4, 1'b0, 32'h0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
